// File: rtl/tx_arbiter_pkg.sv
// Shared types and helpers for the TX serializer arbiter.
package tx_arbiter_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_e;

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request searching upward from ptr+1.
module tx_arbiter_rr_picker
   import tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NUM_REQ byte producers.
// state      | meaning
// IDLE       | arbitrate req, latch winner byte, pulse ack
// LAUNCH     | single-cycle tx_start, arm start timeout
// WAIT_BUSY  | wait for serializer busy, abort with err on timeout
// WAIT_DONE  | wait for stop-bit flag, pulse done
// GAP        | enforced idle spacing before the next byte
module tx_arbiter
   import tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]            ack_o,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [DATA_W-1:0]             tx_data_o,
   output logic                          tx_start_o,
   input  logic                          tx_busy_i,
   input  logic                          tx_complete_flag_i,
   output logic                          active_o,
   output logic [idx_width(NUM_REQ)-1:0] grant_id_o,
   output logic                          err_o
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = idx_width(TIMEOUT + GAP_CYCLES + 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               err_q, err_d;
   logic               active_q, active_d;
   logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic               pick_valid;
   logic [IDX_W-1:0]   pick_idx;

   tx_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ptr_q     <= IDX_W'(NUM_REQ - 1);
         grant_q   <= '0;
         data_q    <= '0;
         ack_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         active_q  <= 1'b0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         err_q     <= err_d;
         active_q  <= active_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      ack_d     = '0;
      done_d    = '0;
      err_d     = 1'b0;
      active_d  = active_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d           = pick_idx;
               data_d            = req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
               ack_d[pick_idx]   = 1'b1;
               active_d          = 1'b1;
               state_d           = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            // WAIT_BUSY spans TIMEOUT-1 cycles so err lands TIMEOUT cycles after LAUNCH.
            to_cnt_d = CNT_W'(TIMEOUT - 2);
            state_d  = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (to_cnt_q == '0) begin
               err_d    = 1'b1;
               ptr_d    = grant_q;
               active_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (tx_complete_flag_i) begin
               done_d[grant_q] = 1'b1;
               ptr_d           = grant_q;
               if (GAP_CYCLES == 0) begin
                  active_d = 1'b0;
                  state_d  = ST_IDLE;
               end else begin
                  gap_cnt_d = CNT_W'(GAP_CYCLES - 1);
                  state_d   = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               active_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_start_o = (state_q == ST_LAUNCH);
   end

   assign ack_o      = ack_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign active_o   = active_q;
   assign grant_id_o = grant_q;
   assign tx_data_o  = data_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: event-timeline reference model, emulated serializer, directed and random traffic.
`timescale 1ns/1ps
module tb_tx_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int DATA_W     = 8;
   localparam int GAP_CYCLES = 2;
   localparam int TIMEOUT    = 16;
   localparam int IDX_W      = 2;

   typedef struct {
      longint            c;
      int                id;
      logic [DATA_W-1:0] d;
   } ev_t;

   logic                      clk_i = 1'b0;
   logic                      rst_i = 1'b1;
   logic [NUM_REQ-1:0]        req_i;
   logic [NUM_REQ*DATA_W-1:0] req_data_i;
   logic [NUM_REQ-1:0]        ack_o;
   logic [NUM_REQ-1:0]        done_o;
   logic [DATA_W-1:0]         tx_data_o;
   logic                      tx_start_o;
   logic                      tx_busy_i;
   logic                      tx_complete_flag_i;
   logic                      active_o;
   logic [IDX_W-1:0]          grant_id_o;
   logic                      err_o;

   tx_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_W     (DATA_W),
      .GAP_CYCLES (GAP_CYCLES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .req_i              (req_i),
      .req_data_i         (req_data_i),
      .ack_o              (ack_o),
      .done_o             (done_o),
      .tx_data_o          (tx_data_o),
      .tx_start_o         (tx_start_o),
      .tx_busy_i          (tx_busy_i),
      .tx_complete_flag_i (tx_complete_flag_i),
      .active_o           (active_o),
      .grant_id_o         (grant_id_o),
      .err_o              (err_o)
   );

   always #5 clk_i = ~clk_i;

   int     n_checks = 0;
   int     n_errors = 0;
   longint k = 0;

   int                pend [NUM_REQ];
   logic [DATA_W-1:0] cur  [NUM_REQ];
   bit                ser_dead;
   bit                ser_stale;
   longint            bs, be;

   // Reference timeline: when the current byte was acked, when busy was seen, when the bus is free again.
   bit                m_x;
   longint            m_A, m_bseen, m_free, m_done_at, m_err_at;
   int                m_grant, m_ptr;
   logic [DATA_W-1:0] m_data;

   ev_t    ack_q[$];
   ev_t    done_q[$];
   longint err_q[$];
   longint start_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, k, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i] && r < 0) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_x = 0; m_A = -100; m_bseen = -1; m_free = 0;
      m_done_at = -1; m_err_at = -1;
      m_grant = 0; m_ptr = NUM_REQ - 1; m_data = '0;
   endtask

   task automatic clear_logs();
      ack_q.delete(); done_q.delete(); err_q.delete(); start_q.delete();
   endtask

   task automatic compare();
      logic [NUM_REQ-1:0] e_ack, e_done;
      e_ack  = (k == m_A) ? (NUM_REQ'(1) << m_grant) : '0;
      e_done = (k == m_done_at) ? (NUM_REQ'(1) << m_grant) : '0;
      chk("ack", ack_o, e_ack);
      chk("done", done_o, e_done);
      chk("err", err_o, (k == m_err_at));
      chk("tx_start", tx_start_o, (k == m_A));
      chk("active", active_o, (k >= m_A) && (m_x || k < m_free));
      chk("grant_id", grant_id_o, m_grant);
      chk("tx_data", tx_data_o, m_data);
      if (ack_o != '0) ack_q.push_back('{k, onehot_idx(ack_o), tx_data_o});
      if (done_o != '0) done_q.push_back('{k, onehot_idx(done_o), tx_data_o});
      if (err_o) err_q.push_back(k);
      if (tx_start_o) start_q.push_back(k);
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ack_o[i] && pend[i] > 0) begin
            pend[i]--;
            cur[i] = DATA_W'($urandom);
         end
         req_i[i] = (pend[i] > 0);
         req_data_i[i*DATA_W +: DATA_W] = cur[i];
      end
      if (tx_start_o && !ser_dead) begin
         bs = k + 2 + longint'($urandom_range(0, 2));
         be = bs + longint'($urandom_range(2, 5));
      end
      tx_busy_i = (k >= bs && k < be);
      if (k == be) tx_complete_flag_i = 1'b1;
      else if (!ser_stale || k == bs) tx_complete_flag_i = 1'b0;
   endtask

   task automatic model_step();
      int w;
      if (m_x) begin
         if (m_bseen < 0) begin
            if (k >= m_A + 1) begin
               if (tx_busy_i) m_bseen = k;
               else if (k == m_A + TIMEOUT - 1) begin
                  m_err_at = k + 1; m_free = k + 1; m_x = 0; m_ptr = m_grant;
               end
            end
         end else if (k > m_bseen && tx_complete_flag_i) begin
            m_done_at = k + 1; m_free = k + 1 + GAP_CYCLES; m_x = 0; m_ptr = m_grant;
         end
      end else if (k >= m_free && req_i != '0) begin
         w = -1;
         for (int i = 1; i <= NUM_REQ; i++)
            if (w < 0 && req_i[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
         m_grant = w; m_data = cur[w]; m_A = k + 1; m_x = 1; m_bseen = -1;
      end
   endtask

   task automatic cycle();
      @(negedge clk_i);
      k++;
      compare();
      drive();
      model_step();
   endtask

   function automatic bit all_idle();
      bit r;
      r = !m_x && (k >= m_free);
      for (int i = 0; i < NUM_REQ; i++) if (pend[i] != 0) r = 0;
      return r;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (!all_idle() && n < 3000) begin
         cycle();
         n++;
      end
      chk("drain_bound", all_idle(), 1);
      repeat (3) cycle();
   endtask

   // Called right after a negedge: asserts reset asynchronously mid-cycle.
   task automatic do_reset();
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_ack", ack_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_start", tx_start_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_grant", grant_id_o, 0);
      chk("rst_data", tx_data_o, 0);
      model_reset();
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
      req_i = '0; tx_busy_i = 1'b0; tx_complete_flag_i = 1'b0;
      bs = -1; be = -1; ser_dead = 0; ser_stale = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t0;
      int     fair_exp [6];
      int     n3;
      bit     reached;
      fair_exp = '{0, 1, 2, 3, 0, 1};
      req_i = '0; req_data_i = '0; tx_busy_i = 1'b0; tx_complete_flag_i = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; cur[i] = '0; end
      bs = -1; be = -1; ser_dead = 0; ser_stale = 0;
      model_reset();
      do_reset();

      // single byte from requester 1
      clear_logs();
      pend[1] = 1; cur[1] = 8'hA5; t0 = k + 1;
      drain();
      chk("single_ack_count", ack_q.size(), 1);
      chk("single_start_count", start_q.size(), 1);
      chk("single_done_count", done_q.size(), 1);
      if (ack_q.size() > 0) begin
         chk("single_ack_id", ack_q[0].id, 1);
         chk("single_ack_latency", ack_q[0].c - t0, 1);
         chk("single_data", ack_q[0].d, 8'hA5);
      end
      if (start_q.size() > 0) chk("single_start_latency", start_q[0] - t0, 1);
      if (done_q.size() > 0) chk("single_done_id", done_q[0].id, 1);
      chk("single_active_end", active_o, 0);

      // contention between 0 and 2
      do_reset(); clear_logs();
      pend[0] = 1; cur[0] = 8'h11; pend[2] = 1; cur[2] = 8'h22;
      drain();
      chk("cont_ack_count", ack_q.size(), 2);
      chk("cont_done_count", done_q.size(), 2);
      if (ack_q.size() == 2 && done_q.size() == 2) begin
         chk("cont_first_id", ack_q[0].id, 0);
         chk("cont_first_data", ack_q[0].d, 8'h11);
         chk("cont_second_id", ack_q[1].id, 2);
         chk("cont_second_data", ack_q[1].d, 8'h22);
         chk("cont_done0_id", done_q[0].id, 0);
         chk("cont_gap", ack_q[1].c - done_q[0].c, GAP_CYCLES + 1);
      end

      // fairness with all requests held
      do_reset(); clear_logs();
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 2;
      drain();
      chk("fair_ack_count", ack_q.size(), 8);
      for (int i = 0; i < 6; i++)
         if (i < ack_q.size()) chk($sformatf("fair_order_%0d", i), ack_q[i].id, fair_exp[i]);

      // timeout with a dead serializer
      do_reset(); clear_logs();
      ser_dead = 1; pend[0] = 2; pend[1] = 1;
      drain();
      ser_dead = 0;
      chk("to_err_count", err_q.size(), 3);
      chk("to_done_count", done_q.size(), 0);
      if (err_q.size() > 0 && start_q.size() > 0) chk("to_latency", err_q[0] - start_q[0], TIMEOUT);
      if (ack_q.size() == 3) begin
         chk("to_order_0", ack_q[0].id, 0);
         chk("to_order_1", ack_q[1].id, 1);
         chk("to_order_2", ack_q[2].id, 0);
      end

      // stale stop-bit flag held between bytes
      do_reset(); clear_logs();
      ser_stale = 1; pend[2] = 3;
      drain();
      ser_stale = 0;
      chk("stale_done_count", done_q.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < done_q.size() && i < ack_q.size())
            chk($sformatf("stale_done_late_%0d", i), (done_q[i].c - ack_q[i].c) >= 5, 1);

      // reset while waiting for the stop bit
      do_reset(); clear_logs();
      pend[3] = 1;
      reached = 0;
      for (int i = 0; i < 60 && !reached; i++) begin
         cycle();
         reached = m_x && (m_bseen >= 0) && (m_bseen < k);
      end
      chk("rst_reach_wait_done", reached, 1);
      do_reset();
      pend[0] = 1; pend[2] = 1;
      drain();
      if (ack_q.size() > 1) chk("rst_next_grant", ack_q[1].id, 0);
      n3 = 0;
      foreach (done_q[i]) if (done_q[i].id == 3) n3++;
      chk("rst_no_done3", n3, 0);
      chk("rst_done_count", done_q.size(), 2);

      // randomized traffic
      do_reset(); clear_logs();
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            ser_dead  = ($urandom_range(0, 4) == 0);
            ser_stale = $urandom_range(0, 1) == 1;
         end
         if ($urandom_range(0, 7) == 0) begin
            int r;
            r = $urandom_range(0, NUM_REQ - 1);
            if (pend[r] == 0) pend[r] = $urandom_range(1, 3);
         end
         cycle();
      end
      ser_dead = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin scheduler that shares one UART transmit serializer between NUM_REQ byte producers. It latches the winning requester's byte, issues a single-cycle start to the serializer and tracks the serializer's busy/complete handshake. It reports per-requester accept and done pulses, and supervises the serializer with a start timeout. It sits between the producer blocks (echo logic, status reporters) and the TX serializer, and is the only driver of the serializer's data and start inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- GAP_CYCLES, 2, idle clk cycles enforced between consecutive bytes (0 allowed)
- TIMEOUT, 16, max cycles from start pulse to serializer busy before abort (≥2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester transmit request, level
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
- ack  out  NUM_REQ  one-cycle pulse: byte of requester i latched
- done  out  NUM_REQ  one-cycle pulse: byte of requester i reached stop bit
- tx_data  out  DATA_W  byte to serializer, stable from ack until next ack
- tx_start  out  1  one-cycle start pulse to serializer
- tx_busy  in  1  serializer busy
- tx_complete_flag  in  1  serializer stop-bit flag
- active  out  1  high from ack until return to IDLE
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req, the winner is the first set bit searching upward from ptr+1 (mod NUM_REQ). Register grant_id and tx_data <= winner's byte, pulse ack[winner], set active, go to LAUNCH. No req: stay.
- LAUNCH: tx_start=1 for exactly this cycle, load timeout counter, go to WAIT_BUSY. The start pulse must never exceed one cycle: the serializer restarts from its stop bit if start is still high.
- WAIT_BUSY: tx_busy=1 → WAIT_DONE. Counter expired with tx_busy=0 → pulse err, ptr <= grant_id, go to IDLE without done.
- WAIT_DONE: tx_complete_flag=1 → pulse done[grant_id], ptr <= grant_id, go to GAP (or IDLE if GAP_CYCLES=0). The flag is qualified only in this state, so a stale high flag from the previous byte is ignored.
- GAP: count GAP_CYCLES cycles with tx_start=0, then go to IDLE and clear active.
- req is sampled only in IDLE. A req dropped after ack does not cancel the byte. A req still high after ack is treated as a new byte and competes at the next IDLE.
- Requesters drop req on ack for single bytes. Holding req streams bytes, interleaved fairly by round-robin.
- Reset values: state IDLE; ptr = NUM_REQ-1, so requester 0 has first priority; ack, done, tx_start, err, active = 0; tx_data = 0; grant_id = 0; counters = 0.
- Reset mid-transfer aborts immediately and emits no done. The serializer shares the reset and restarts clean.

## Timing
- Cycle 0: IDLE sees req. Edge 0→1: ack, tx_data and grant_id valid in cycle 1 (LAUNCH, tx_start=1).
- The serializer samples start at edge 1→2; tx_busy is visible in cycle 3 at the earliest.
- done asserts in the cycle after tx_complete_flag is first seen high in WAIT_DONE.
- Back-to-back bytes: the next ack comes GAP_CYCLES+1 cycles after done.
- Timeout: err is asserted TIMEOUT cycles after LAUNCH if tx_busy never rises.
- Simultaneous requests resolve in a single IDLE cycle. At most one ack bit is set per cycle, and likewise for done.

## Structure
- Shared package (tx_pkg): state encoding constants, DATA_W default, $clog2 helper for grant_id width.
- One sub-module: rr_picker — combinational round-robin selector taking req and ptr, producing a valid flag and the winner index.
- Counters (timeout, gap) stay in tx_arbiter.

## Test plan
- Single byte: req[1]=1 with byte 8'hA5, req dropped on ack → ack[1] in cycle 1, tx_start high for exactly 1 cycle, tx_data=8'hA5, done[1] after the stop bit, active low afterwards.
- Contention: req[0] and req[2] high together with bytes 8'h11 and 8'h22, each held until its ack → bytes transmitted 8'h11 then 8'h22, with GAP_CYCLES idle cycles between done[0] and ack[2].
- Fairness: all four req held continuously → grant order 0,1,2,3,0,1; no ack while active=1.
- Timeout: tx_busy forced to 0 → err pulse TIMEOUT cycles after LAUNCH, no done, ptr advances so the next grant goes to the next requester.
- Stale flag: tx_complete_flag held high from the previous byte → no early done; done only after busy then the new stop bit.
- Reset mid-transfer: assert reset in WAIT_DONE → all outputs return to reset values on the same edge, no done pulse, and the next request after release is granted to requester 0 first.
